// File: rtl/user_rdwr_master.sv
// Avalon-MM single-word read/write master driven by a debounced pushbutton.
// Optional readback comparator enabled by defining USER_RDWR_READBACK_CHECK_EN.
module user_rdwr_master #(
   parameter int          ADDR_W          = 28,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter logic [31:0] SPAN            = 32'h0800_0000,
   parameter logic [31:0] PATTERN         = 32'hA5A5_A5A5,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter int          TIMEOUT         = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rdwr_cntl,
   input  logic              n_action,
   input  logic              add_data_sel,
   output logic [31:0]       rdwr_address,
   output logic [31:0]       display_data,
   output logic [15:0]       debug_flag,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   // One spare bit so the timer cannot wrap past the limit between states.
   localparam int TO_W = $clog2(TIMEOUT) + 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, ERR} state_t;

   logic            sync1_q, sync2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            armed_q, armed_d;
   logic            act_q, act_d;
   state_t          state_q, state_d;
   logic [TO_W-1:0] tmr_q, tmr_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     last_q, last_d;
   logic            done_q, done_d;
   logic            mism_q, mism_d;
   logic [31:0]     disp_q, disp_d;
   logic [15:0]     dbg_q, dbg_d;
   logic            rd_q, rd_d, wr_q, wr_d;
   logic [32:0]     addr_nxt;

   // Debouncer: armed waits for a long low, disarmed waits for a long high.
   always_comb begin
      db_cnt_d = db_cnt_q;
      armed_d  = armed_q;
      act_d    = 1'b0;
      if (armed_q == !sync2_q) begin
         if (db_cnt_q == DB_MAX) begin
            db_cnt_d = '0;
            armed_d  = !armed_q;
            act_d    = armed_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   assign addr_nxt = {1'b0, addr_q} + 33'd4;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      addr_d  = addr_q;
      last_d  = last_q;
      done_d  = done_q;
      mism_d  = mism_q;
      unique case (state_q)
         IDLE: if (act_q) begin
            state_d = rdwr_cntl ? WR_REQ : RD_REQ;
            tmr_d   = '0;
         end
         WR_REQ: begin
            tmr_d = tmr_q + 1'b1;
            if (!avm_waitrequest) begin
               state_d = IDLE;
               last_d  = addr_q ^ PATTERN;
               done_d  = 1'b1;
               mism_d  = 1'b0;
               addr_d  = (addr_nxt >= ({1'b0, BASE_ADDR} + {1'b0, SPAN})) ? BASE_ADDR : addr_nxt[31:0];
            end else if (tmr_q >= TO_MAX) begin
               state_d = ERR;
            end
         end
         RD_REQ: begin
            tmr_d = tmr_q + 1'b1;
            if (!avm_waitrequest)     state_d = RD_WAIT;
            else if (tmr_q >= TO_MAX) state_d = ERR;
         end
         RD_WAIT: begin
            tmr_d = tmr_q + 1'b1;
            if (avm_readdatavalid) begin
               state_d = IDLE;
               last_d  = avm_readdata;
               done_d  = 1'b1;
`ifdef USER_RDWR_READBACK_CHECK_EN
               if (avm_readdata != (addr_q ^ PATTERN)) mism_d = 1'b1;
`endif
               addr_d  = (addr_nxt >= ({1'b0, BASE_ADDR} + {1'b0, SPAN})) ? BASE_ADDR : addr_nxt[31:0];
            end else if (tmr_q >= TO_MAX) begin
               state_d = ERR;
            end
         end
         ERR: if (act_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifndef USER_RDWR_READBACK_CHECK_EN
      mism_d = 1'b0;
`endif
   end

   // Bus strobes and status are decoded from the next state so they are registered.
   always_comb begin
      wr_d   = (state_d == WR_REQ);
      rd_d   = (state_d == RD_REQ);
      disp_d = add_data_sel ? addr_q : last_q;
      dbg_d  = 16'd0;
      unique case (state_d)
         IDLE:    dbg_d = mism_d ? 16'd6 : (done_d ? 16'd1 : 16'd0);
         WR_REQ:  dbg_d = 16'd2;
         RD_REQ:  dbg_d = 16'd3;
         RD_WAIT: dbg_d = 16'd4;
         ERR:     dbg_d = 16'd5;
         default: dbg_d = 16'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         db_cnt_q <= '0;
         armed_q  <= 1'b0;
         act_q    <= 1'b0;
         state_q  <= IDLE;
         tmr_q    <= '0;
         addr_q   <= BASE_ADDR;
         last_q   <= '0;
         done_q   <= 1'b0;
         mism_q   <= 1'b0;
         disp_q   <= '0;
         dbg_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         sync1_q  <= n_action;
         sync2_q  <= sync1_q;
         db_cnt_q <= db_cnt_d;
         armed_q  <= armed_d;
         act_q    <= act_d;
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
         done_q   <= done_d;
         mism_q   <= mism_d;
         disp_q   <= disp_d;
         dbg_q    <= dbg_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   assign rdwr_address   = addr_q;
   assign display_data   = disp_q;
   assign debug_flag     = dbg_q;
   assign avm_address    = addr_q[ADDR_W-1:0];
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = addr_q ^ PATTERN;
   assign avm_byteenable = 4'hF;
endmodule

// File: tb/tb_user_rdwr_master.sv
// Directed bench for user_rdwr_master with a small Avalon slave model.
module tb_user_rdwr_master;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rdwr_cntl = 1'b0;
   logic        n_action = 1'b1;
   logic        add_data_sel = 1'b0;
   logic [31:0] rdwr_address, display_data, avm_writedata;
   logic [15:0] debug_flag;
   logic [27:0] avm_address;
   logic        avm_read, avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata = 32'h0;
   logic        avm_readdatavalid = 1'b0;
   logic        avm_waitrequest = 1'b0;

   int checks = 0, failures = 0;
   int wr_cycles = 0, rd_cycles = 0;
   logic [31:0] wr_data_seen = 32'h0;
   logic [27:0] wr_addr_seen = 28'h0;
   int stuck = 0, hold = 0, age = 0, rv_cnt = 0;
   logic [31:0] rd_data = 32'h0;
   int w0, r0;

   user_rdwr_master #(
      .DEBOUNCE_CYCLES(4), .TIMEOUT(16), .SPAN(32'h10)
   ) dut (
      .clk(clk), .reset(reset), .rdwr_cntl(rdwr_cntl), .n_action(n_action),
      .add_data_sel(add_data_sel), .rdwr_address(rdwr_address),
      .display_data(display_data), .debug_flag(debug_flag),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   // Slave model and bus monitor, evaluated mid-cycle.
   always @(negedge clk) begin
      if (avm_write) begin
         wr_cycles++;
         wr_data_seen = avm_writedata;
         wr_addr_seen = avm_address;
      end
      if (avm_read) rd_cycles++;
      avm_readdatavalid = 1'b0;
      if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rd_data;
         end
      end
      if ((avm_write || avm_read) && (stuck != 0 || age < hold)) begin
         avm_waitrequest = 1'b1;
         age++;
      end else begin
         avm_waitrequest = 1'b0;
         if (avm_read) rv_cnt = 3;
         if (!(avm_write || avm_read)) age = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic press();
      n_action = 1'b0;
      step(10);
      n_action = 1'b1;
      step(30);
   endtask

   initial begin
      step(2);
      chk("rst_wr", {31'd0, avm_write}, 32'd0);
      chk("rst_rd", {31'd0, avm_read}, 32'd0);
      chk("rst_addr", rdwr_address, 32'h0);
      chk("rst_disp", display_data, 32'h0);
      chk("rst_dbg", {16'd0, debug_flag}, 32'd0);
      chk("rst_be", {28'd0, avm_byteenable}, 32'hF);
      reset = 1'b0;
      step(10);

      // write at 0 with two waitrequest cycles
      rdwr_cntl = 1'b1; hold = 2; w0 = wr_cycles;
      press();
      chk("wr_cycles", wr_cycles - w0, 3);
      chk("wr_data", wr_data_seen, 32'hA5A5A5A5);
      chk("wr_addr", {4'd0, wr_addr_seen}, 32'h0);
      chk("wr_next", rdwr_address, 32'h4);
      chk("wr_dbg", {16'd0, debug_flag}, 32'd1);
      chk("wr_disp", display_data, 32'hA5A5A5A5);

      // read at 4
      rdwr_cntl = 1'b0; hold = 0; rd_data = 32'hA5A5A5A1; r0 = rd_cycles;
      press();
      chk("rd_cycles", rd_cycles - r0, 1);
      chk("rd_disp", display_data, 32'hA5A5A5A1);
      chk("rd_next", rdwr_address, 32'h8);
      chk("rd_dbg", {16'd0, debug_flag}, 32'd1);
      add_data_sel = 1'b1;
      step(1);
      chk("sel_addr", display_data, 32'h8);
      add_data_sel = 1'b0;
      step(1);
      chk("sel_data", display_data, 32'hA5A5A5A1);

      // bounce: three short glitches, no access
      w0 = wr_cycles; r0 = rd_cycles; rdwr_cntl = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_action = 1'b0; step(2);
         n_action = 1'b1; step(6);
      end
      step(20);
      chk("bnc_none", (wr_cycles - w0) + (rd_cycles - r0), 0);
      chk("bnc_addr", rdwr_address, 32'h8);
      press();
      chk("bnc_one", wr_cycles - w0, 1);
      chk("bnc_data", wr_data_seen, 32'hA5A5A5AD);
      chk("bnc_next", rdwr_address, 32'hC);

      // timeout on a stuck read
      rdwr_cntl = 1'b0; stuck = 1; r0 = rd_cycles;
      press();
      chk("to_cycles", rd_cycles - r0, 16);
      chk("to_dbg", {16'd0, debug_flag}, 32'd5);
      chk("to_addr", rdwr_address, 32'hC);
      stuck = 0; w0 = wr_cycles; r0 = rd_cycles;
      press();
      chk("err_none", (wr_cycles - w0) + (rd_cycles - r0), 0);
      chk("err_dbg", {16'd0, debug_flag}, 32'd1);
      chk("err_addr", rdwr_address, 32'hC);

      // wrap: write at C returns to 0, then a full lap
      rdwr_cntl = 1'b1;
      press();
      chk("wrap0", rdwr_address, 32'h0);
      for (int i = 0; i < 4; i++) begin
         press();
         chk("lap_data", wr_data_seen, 32'hA5A5A5A5 ^ (i * 4));
         chk("lap_addr", rdwr_address, ((i + 1) * 4) & 32'hF);
      end

      // readback of a value that does not match the pattern
      rdwr_cntl = 1'b0; rd_data = 32'hDEADBEEF;
      press();
      chk("rb_disp", display_data, 32'hDEADBEEF);
      chk("rb_addr", rdwr_address, 32'h4);
`ifdef USER_RDWR_READBACK_CHECK_EN
      chk("rb_dbg", {16'd0, debug_flag}, 32'd6);
`else
      chk("rb_dbg", {16'd0, debug_flag}, 32'd1);
`endif
      rdwr_cntl = 1'b1;
      press();
      chk("rb_clr", {16'd0, debug_flag}, 32'd1);
      chk("rb_clr_addr", rdwr_address, 32'h8);

      // reset while a write is pending
      stuck = 1;
      n_action = 1'b0;
      step(9);
      chk("mid_wr", {31'd0, avm_write}, 32'd1);
      reset = 1'b1;
      step(1);
      chk("mid_drop", {31'd0, avm_write}, 32'd0);
      chk("mid_addr", rdwr_address, 32'h0);
      chk("mid_dbg", {16'd0, debug_flag}, 32'd0);
      reset = 1'b0; n_action = 1'b1; stuck = 0;
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
